// File: rtl/branch_target_buffer.sv
// Four-entry direct-mapped branch target buffer with 2-bit saturating predictors.
// Combinational fetch lookup and mem-stage mispredict detection; clocked entry update and statistics.
module branch_target_buffer #(
    parameter int unsigned ENTRIES  = 4,
    parameter logic [1:0]  CNT_INIT = 2'b10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] if_pc,
    output logic        if_taken,
    output logic [31:0] if_target,
    output logic [1:0]  if_index,
    input  logic        mem_branch,
    input  logic [31:0] mem_pc,
    input  logic [1:0]  mem_index,
    input  logic        mem_pred_taken,
    input  logic [31:0] mem_pred_target,
    input  logic        mem_br_take,
    input  logic [31:0] mem_br_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [15:0] branch_cnt,
    output logic [15:0] mispred_cnt
);

    localparam int unsigned TAG_W  = 28;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STAT_W = 16;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [1:0]        cnt_q    [ENTRIES];

    logic lookup_hit;
    logic upd_hit;
    logic unused_pc_bits;

    assign unused_pc_bits = &{1'b0, if_pc[1:0]};
    assign if_index       = if_pc[3:2];

    // Fetch-side lookup; reads pre-update contents (no bypass)
    always_comb begin
        lookup_hit = valid_q[if_index] && (tag_q[if_index] == if_pc[31:4]);
        if_taken   = lookup_hit && cnt_q[if_index][1];
        if_target  = if_taken ? target_q[if_index] : '0;
    end

    // Resolution check against the prediction carried down the pipe
    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = '0;
        if (mem_branch) begin
            mispredict  = (mem_pred_taken != mem_br_take) ||
                          (mem_br_take && (mem_pred_target != mem_br_target));
            redirect_pc = mem_br_take ? mem_br_target : ADDR_W'(mem_pc + 32'd4);
        end
    end

    assign upd_hit = valid_q[mem_index] && (tag_q[mem_index] == mem_pc[31:4]);

    // Entry update: train on a hit, allocate on a taken miss
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else if (mem_branch) begin
            if (upd_hit) begin
                if (mem_br_take) begin
                    target_q[mem_index] <= mem_br_target;
                    if (cnt_q[mem_index] != 2'b11) begin
                        cnt_q[mem_index] <= 2'(cnt_q[mem_index] + 2'd1);
                    end
                end else if (cnt_q[mem_index] != 2'b00) begin
                    cnt_q[mem_index] <= 2'(cnt_q[mem_index] - 2'd1);
                end
            end else if (mem_br_take) begin
                valid_q[mem_index]  <= 1'b1;
                tag_q[mem_index]    <= mem_pc[31:4];
                target_q[mem_index] <= mem_br_target;
                cnt_q[mem_index]    <= CNT_INIT;
            end
        end
    end

    // Saturating statistics
    always_ff @(posedge CLK) begin
        if (RST) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (mem_branch && (branch_cnt != '1)) begin
                branch_cnt <= STAT_W'(branch_cnt + 16'd1);
            end
            if (mispredict && (mispred_cnt != '1)) begin
                mispred_cnt <= STAT_W'(mispred_cnt + 16'd1);
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus randomized
// traffic against a table-based behavioural model.
module tb_branch_target_buffer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] if_pc;
    logic        if_taken;
    logic [31:0] if_target;
    logic [1:0]  if_index;
    logic        mem_branch;
    logic [31:0] mem_pc;
    logic [1:0]  mem_index;
    logic        mem_pred_taken;
    logic [31:0] mem_pred_target;
    logic        mem_br_take;
    logic [31:0] mem_br_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;

    branch_target_buffer dut (
        .CLK             (CLK),
        .RST             (RST),
        .if_pc           (if_pc),
        .if_taken        (if_taken),
        .if_target       (if_target),
        .if_index        (if_index),
        .mem_branch      (mem_branch),
        .mem_pc          (mem_pc),
        .mem_index       (mem_index),
        .mem_pred_taken  (mem_pred_taken),
        .mem_pred_target (mem_pred_target),
        .mem_br_take     (mem_br_take),
        .mem_br_target   (mem_br_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .branch_cnt      (branch_cnt),
        .mispred_cnt     (mispred_cnt)
    );

    always #5 CLK = ~CLK;

    int n_vectors = 0;
    int n_miscompares = 0;

    // Reference model: a plain table of entries plus integer statistics
    bit          m_valid  [4];
    bit [27:0]   m_tag    [4];
    bit [31:0]   m_target [4];
    int          m_cnt    [4];
    int          m_branch;
    int          m_mispred;

    // Last observed combinational outputs, for directed checks
    logic        obs_taken;
    logic [31:0] obs_target;
    logic [1:0]  obs_index;
    logic        obs_mis;
    logic [31:0] obs_redirect;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_target[i] = '0; m_cnt[i] = 0;
        end
        m_branch = 0;
        m_mispred = 0;
    endtask

    function automatic bit model_mis(input bit br, input bit pt, input bit [31:0] ptgt,
                                     input bit tk, input bit [31:0] tgt);
        return br && ((pt != tk) || (tk && ptgt != tgt));
    endfunction

    function automatic bit model_pred(input bit [31:0] pc);
        int e = int'(pc[3:2]);
        return m_valid[e] && (m_tag[e] == pc[31:4]) && (m_cnt[e] >= 2);
    endfunction

    task automatic model_update(input bit br, input bit [31:0] mpc, input bit [1:0] midx,
                                input bit pt, input bit [31:0] ptgt,
                                input bit tk, input bit [31:0] tgt);
        int i = int'(midx);
        if (br) begin
            if (m_valid[i] && m_tag[i] == mpc[31:4]) begin
                if (tk) begin
                    m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
                    m_target[i] = tgt;
                end else begin
                    m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
                end
            end else if (tk) begin
                m_valid[i] = 1; m_tag[i] = mpc[31:4]; m_target[i] = tgt; m_cnt[i] = 2;
            end
            m_branch = (m_branch + 1 > 65535) ? 65535 : m_branch + 1;
        end
        if (model_mis(br, pt, ptgt, tk, tgt))
            m_mispred = (m_mispred + 1 > 65535) ? 65535 : m_mispred + 1;
    endtask

    // One cycle: drive, check combinational outputs, clock, check statistics
    task automatic step(input logic [31:0] ipc, input logic br, input logic [31:0] mpc,
                        input logic [1:0] midx, input logic pt, input logic [31:0] ptgt,
                        input logic tk, input logic [31:0] tgt);
        bit          e_taken;
        bit [31:0]   e_target;
        bit          e_mis;
        bit [31:0]   e_redir;
        if_pc = ipc; mem_branch = br; mem_pc = mpc; mem_index = midx;
        mem_pred_taken = pt; mem_pred_target = ptgt; mem_br_take = tk; mem_br_target = tgt;
        #1;
        e_taken  = model_pred(ipc);
        e_target = e_taken ? m_target[ipc[3:2]] : 32'h0;
        e_mis    = model_mis(br, pt, ptgt, tk, tgt);
        e_redir  = !br ? 32'h0 : (tk ? tgt : mpc + 32'd4);
        obs_taken = if_taken; obs_target = if_target; obs_index = if_index;
        obs_mis = mispredict; obs_redirect = redirect_pc;
        check("if_taken", 32'(if_taken), 32'(e_taken));
        check("if_target", if_target, e_target);
        check("if_index", 32'(if_index), 32'(ipc[3:2]));
        check("mispredict", 32'(mispredict), 32'(e_mis));
        check("redirect_pc", redirect_pc, e_redir);
        @(posedge CLK);
        model_update(br, mpc, midx, pt, ptgt, tk, tgt);
        #1;
        check("branch_cnt", 32'(branch_cnt), 32'(m_branch));
        check("mispred_cnt", 32'(mispred_cnt), 32'(m_mispred));
    endtask

    task automatic idle(input logic [31:0] ipc);
        step(ipc, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        mem_branch = 1'b0;
        @(posedge CLK);
        model_reset();
        #1;
        RST = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        if ($urandom_range(0, 15) == 0) pc = 32'hFFFF_FFFC;
        else pc = 32'h40 + ($urandom_range(0, 3) << 4) + ($urandom_range(0, 3) << 2);
        return pc;
    endfunction

    initial begin
        RST = 1'b1; if_pc = '0; mem_branch = 0; mem_pc = '0; mem_index = '0;
        mem_pred_taken = 0; mem_pred_target = '0; mem_br_take = 0; mem_br_target = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset, then lookup
        idle(32'h40);
        check("rst_taken", 32'(obs_taken), 32'h0);
        check("rst_target", obs_target, 32'h0);
        check("rst_index", 32'(obs_index), 32'h0);

        // Allocate, then hit
        step(32'h44, 1, 32'h44, 2'd1, 0, 32'h0, 1, 32'h100);
        check("alloc_mis", 32'(obs_mis), 32'h1);
        check("alloc_redir", obs_redirect, 32'h100);
        check("alloc_same_cycle", 32'(obs_taken), 32'h0);
        idle(32'h44);
        check("hit_taken", 32'(obs_taken), 32'h1);
        check("hit_target", obs_target, 32'h100);
        check("hit_index", 32'(obs_index), 32'h1);

        // Saturation walk: 2 -> 3 -> 3, then 2, 1, 0
        step(32'h44, 1, 32'h44, 2'd1, 1, 32'h100, 1, 32'h100);
        step(32'h44, 1, 32'h44, 2'd1, 1, 32'h100, 1, 32'h100);
        step(32'h44, 1, 32'h44, 2'd1, 1, 32'h100, 0, 32'h0);
        check("sat_nt1_redir", obs_redirect, 32'h48);
        step(32'h44, 1, 32'h44, 2'd1, 1, 32'h100, 0, 32'h0);
        check("sat_after_nt1", 32'(obs_taken), 32'h1);
        check("sat_nt2_redir", obs_redirect, 32'h48);
        step(32'h44, 1, 32'h44, 2'd1, 0, 32'h0, 0, 32'h0);
        check("sat_after_nt2", 32'(obs_taken), 32'h0);
        check("sat_nt3_nomis", 32'(obs_mis), 32'h0);
        idle(32'h44);
        check("sat_after_nt3", 32'(obs_taken), 32'h0);

        // Conflict eviction
        do_reset();
        step(32'h0, 1, 32'h44, 2'd1, 0, 32'h0, 1, 32'h100);
        step(32'h0, 1, 32'h54, 2'd1, 0, 32'h0, 1, 32'h200);
        idle(32'h44);
        check("evict_old", 32'(obs_taken), 32'h0);
        idle(32'h54);
        check("evict_new_tgt", obs_target, 32'h200);

        // Same-cycle read/write and wrong-target mispredict
        do_reset();
        step(32'h0, 1, 32'h44, 2'd1, 0, 32'h0, 1, 32'h100);
        step(32'h44, 1, 32'h44, 2'd1, 1, 32'h100, 1, 32'h180);
        check("rw_old_tgt", obs_target, 32'h100);
        check("wrong_tgt_mis", 32'(obs_mis), 32'h1);
        check("wrong_tgt_redir", obs_redirect, 32'h180);
        idle(32'h44);
        check("rw_new_tgt", obs_target, 32'h180);

        // PC wrap on not-taken redirect
        step(32'h0, 1, 32'hFFFF_FFFC, 2'd3, 1, 32'h10, 0, 32'h0);
        check("wrap_redir", obs_redirect, 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] mpc;
            logic [1:0]  midx;
            logic        pt;
            logic [31:0] ptgt;
            logic        tk;
            logic [31:0] tgt;
            mpc  = rand_pc();
            midx = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : mpc[3:2];
            tk   = 1'($urandom_range(0, 1));
            tgt  = 32'h100 + ($urandom_range(0, 3) << 6);
            if ($urandom_range(0, 1) == 1) begin
                pt   = model_pred(mpc);
                ptgt = pt ? m_target[mpc[3:2]] : 32'h0;
            end else begin
                pt   = 1'($urandom_range(0, 1));
                ptgt = 32'h100 + ($urandom_range(0, 3) << 6);
            end
            if ($urandom_range(0, 49) == 0) do_reset();
            else step(rand_pc(), 1'($urandom_range(0, 3) != 0), mpc, midx, pt, ptgt, tk, tgt);
        end

        // Statistics saturation
        do_reset();
        mem_branch = 1; mem_pc = 32'h80; mem_index = 2'd0;
        mem_pred_taken = 0; mem_pred_target = 32'h0; mem_br_take = 1; mem_br_target = 32'h300;
        for (int n = 0; n < 70000; n++) begin
            @(posedge CLK);
            model_update(1, 32'h80, 2'd0, 0, 32'h0, 1, 32'h300);
        end
        #1;
        check("stat_branch_sat", 32'(branch_cnt), 32'(m_branch));
        check("stat_branch_ffff", 32'(branch_cnt), 32'hFFFF);
        check("stat_mispred_ffff", 32'(mispred_cnt), 32'hFFFF);
        if_pc = 32'h80;
        #1;
        check("pre_rst_taken", 32'(if_taken), 32'h1);

        // Reset wins over a simultaneous update; mispredict stays input-driven
        RST = 1'b1;
        mem_pc = 32'h90; mem_index = 2'd0; mem_br_target = 32'h400;
        #1;
        check("rst_mis_live", 32'(mispredict), 32'h1);
        check("rst_redir_live", redirect_pc, 32'h400);
        @(posedge CLK);
        model_reset();
        #1;
        RST = 1'b0;
        mem_branch = 1'b0;
        #1;
        check("rst_branch_cnt", 32'(branch_cnt), 32'h0);
        check("rst_mispred_cnt", 32'(mispred_cnt), 32'h0);
        for (int i = 0; i < 4; i++) begin
            idle(32'h80 + 32'(i * 4));
            check("rst_entry_taken", 32'(obs_taken), 32'h0);
        end
        idle(32'h90);
        check("rst_over_update", 32'(obs_taken), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Four-entry direct-mapped branch target buffer with 2-bit saturating predictors. Sits beside the fetch stage: it answers the fetch PC combinationally with the `btb_taken`/`btb_target`/`btb_index` triple carried in the ifetch latch. It takes resolved branch outcomes from the memory stage (`beq`/`bne`, `brTake`, `brTarget`, `btb_*` fields of the mem latch), updates its entries, and flags mispredictions with the corrected fetch PC. It also keeps saturating branch/mispredict statistics.

## Interface
- `ENTRIES`, 4: number of entries. Fixed at 4 to match the 2-bit `btb_index` latch field; index = PC[3:2].
- `CNT_INIT`, 2'b10: predictor value written on allocation (weakly taken).
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: reset, synchronous, active-high.
- `if_pc` input 32: current fetch PC.
- `if_taken` output 1: predict taken.
- `if_target` output 32: predicted target; 0 when not taken.
- `if_index` output 2: `if_pc[3:2]`, always driven.
- `mem_branch` input 1: mem-stage instruction is a resolved `beq` or `bne`.
- `mem_pc` input 32: PC of that branch.
- `mem_index` input 2: `btb_index` carried down the pipe; write index.
- `mem_pred_taken` input 1: `btb_taken` carried down the pipe.
- `mem_pred_target` input 32: `btb_target` carried down the pipe.
- `mem_br_take` input 1: actual outcome (`brTake`).
- `mem_br_target` input 32: actual branch target (`brTarget`).
- `mispredict` output 1: flush/redirect request.
- `redirect_pc` output 32: correct next PC.
- `branch_cnt` output 16: resolved branches, saturating.
- `mispred_cnt` output 16: mispredictions, saturating.

## Operation
- Entry contents: `valid`, `tag` = PC[31:4] (28 bits), `target` (32), `cnt` (2).
- Lookup (combinational): with e = entry[`if_pc[3:2]`], hit = `e.valid` && `e.tag == if_pc[31:4]`. `if_taken` = hit && `e.cnt[1]`. `if_target` = `if_taken` ? `e.target` : 0.
- Mispredict (combinational, only when `mem_branch`=1):
  - `mispredict` = (`mem_pred_taken != mem_br_take`) || (`mem_br_take` && `mem_pred_target != mem_br_target`).
  - `redirect_pc` = `mem_br_take` ? `mem_br_target` : `mem_pc + 4`, using 32-bit wrap.
  - When `mem_branch`=0: `mispredict`=0 and `redirect_pc`=0.
- Update (clocked, when `mem_branch`=1, entry e = entry[`mem_index`]):
  - Tag match (`valid` && tag == `mem_pc[31:4]`):
    - taken: `cnt` = min(`cnt`+1, 3) and `target` <= `mem_br_target`.
    - not taken: `cnt` = max(`cnt`-1, 0); `target` unchanged.
  - Miss and taken: allocate. `valid`=1, `tag`=`mem_pc[31:4]`, `target`=`mem_br_target`, `cnt`=`CNT_INIT`. Any previous occupant is replaced.
  - Miss and not taken: no change.
- Statistics: `branch_cnt` += 1 per cycle with `mem_branch`=1. `mispred_cnt` += 1 per cycle with `mispredict`=1. Both hold at 16'hFFFF.

## Timing
- Lookup and mispredict/redirect: zero latency, same cycle.
- Entry write and counter increment take effect at the rising `CLK` edge.
- A lookup in the same cycle as an update to the same entry returns the pre-update contents; there is no bypass. The new contents are visible the next cycle.
- Reset (`RST`=1 at an edge):
  - All `valid`, `tag`, `target` and `cnt` bits are cleared to 0.
  - `branch_cnt` and `mispred_cnt` go to 0.
  - Reset wins over a simultaneous update.
  - Afterwards `if_taken`=0 and `if_target`=0 for any PC.
  - `mispredict` and `redirect_pc` stay purely input-driven during and after reset.
- Allocation from `cnt`=0 state is irrelevant: allocation always loads `CNT_INIT`.
- `mem_pc + 4` at 32'hFFFFFFFC wraps to 0.

## Test plan
- **Reset, then lookup.** Apply reset, then look up `if_pc`=0x40 → `if_taken`=0, `if_target`=0, `if_index`=0.
- **Allocate, then hit.** Resolve `mem_pc`=0x44, taken to 0x100, with pred not-taken → `mispredict`=1, `redirect_pc`=0x100. Next cycle, `if_pc`=0x44 → `if_taken`=1, `if_target`=0x100, `if_index`=1.
- **Saturation walk.** Same branch taken twice → `cnt`=3. Then not-taken three times → `if_taken` is 1, 0, 0 after each. `redirect_pc`=0x48 on each mispredicted not-taken.
- **Conflict eviction.** Allocate 0x44, then resolve 0x54 taken to 0x200 (same index) → `if_pc`=0x44 gives `if_taken`=0, and `if_pc`=0x54 gives target 0x200.
- **Same-cycle read/write.** Update entry 1 while looking up 0x44 in the same cycle → old prediction that cycle, new prediction the next cycle. Also check the wrong-target case: pred taken to 0x100, actual taken to 0x180 → `mispredict`=1.
- **Statistics and reset.** Drive 70000 resolved mispredicting branches → both counters read 0xFFFF. Assert `RST` during an update → all entries invalid, counters 0.
